mult_sequencer: RTL and testbench



---
 rtl/mult_sequencer.sv | 101 ++++++++++
 tb/tb_mult_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// mult_sequencer: sequential unsigned shift-and-add multiplier.
// It accepts two WIDTH-bit operands on start and runs WIDTH add/shift iterations.
// It then publishes the 2*WIDTH-bit product together with a one-cycle done pulse.
module mult_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplr_q, mplr_d;
   // The accumulator carry lives only in sum. After the shift, the top bit of
   // the WIDTH+1-bit accumulator is always zero, so it is not stored.
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic [WIDTH:0]       sum;

   // State and datapath registers, cleared asynchronously by reset_n.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         mplr_q    <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   // Next-state and datapath update: accept in idle, iterate in run, one-cycle done.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      acc_d     = acc_q;
      count_d   = count_q;
      product_d = product_q;
      sum       = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);

      unique case (state_q)
         StIdle: begin
            if (start) begin
               mcand_d = a;
               mplr_d  = b;
               acc_d   = '0;
               count_d = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            // {acc, mplr} <= {sum, mplr} >> 1
            acc_d   = sum[WIDTH:1];
            mplr_d  = {sum[0], mplr_q[WIDTH-1:1]};
            count_d = count_q + 1'b1;
            if (count_q == LastCnt) begin
               product_d = {sum[WIDTH:1], sum[0], mplr_q[WIDTH-1:1]};
               state_d   = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Status outputs decoded directly from the state flops, never from start.
   always_comb begin
      busy    = (state_q == StRun);
      done    = (state_q == StDone);
      product = product_q;
   end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed self-checking bench for mult_sequencer.
module tb_mult_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int unsigned n_checks;
   int unsigned n_errors;
   logic [15:0] last_prod;

   mult_sequencer #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the block idle; returns at the negedge after edge k+9.
   task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] exp);
      start = 1'b1;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
      a     = 8'h5A;
      b     = 8'hC3;
      for (int j = 0; j < 8; j++) begin
         check_val({tag, " busy"}, busy, 1);
         check_val({tag, " no done"}, done, 0);
         check_val({tag, " prod hold"}, product, last_prod);
         @(negedge clk);
      end
      check_val({tag, " done"}, done, 1);
      check_val({tag, " busy off"}, busy, 0);
      check_val({tag, " product"}, product, exp);
      last_prod = exp;
      @(negedge clk);
      check_val({tag, " done off"}, done, 0);
      check_val({tag, " idle"}, busy, 0);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      last_prod = 16'h0000;
      reset_n   = 1'b0;
      start     = 1'b0;
      a         = 8'h00;
      b         = 8'h00;

      // Reset state
      repeat (2) @(negedge clk);
      check_val("reset busy", busy, 0);
      check_val("reset done", done, 0);
      check_val("reset product", product, 16'h0000);
      reset_n = 1'b1;
      @(negedge clk);
      check_val("idle busy", busy, 0);

      // Basic products
      run_op("13x11", 8'd13, 8'd11, 16'h008F);
      run_op("ffxff", 8'hFF, 8'hFF, 16'hFE01);
      run_op("0xa5", 8'h00, 8'hA5, 16'h0000);
      run_op("80x02", 8'h80, 8'h02, 16'h0100);

      // Start re-pulsed during RUN and DONE is ignored
      start = 1'b1; a = 8'd3; b = 8'd5;
      @(negedge clk);                          // after edge k
      start = 1'b0;
      @(negedge clk);                          // k+1
      @(negedge clk);                          // k+2
      start = 1'b1; a = 8'd7; b = 8'd7;
      @(negedge clk);                          // k+3
      start = 1'b0;
      repeat (5) @(negedge clk);               // k+8
      check_val("ign done", done, 1);
      check_val("ign product", product, 16'h000F);
      start = 1'b1; a = 8'd7; b = 8'd7;
      @(negedge clk);                          // k+9
      start = 1'b0;
      check_val("ign done off", done, 0);
      check_val("ign idle", busy, 0);
      for (int j = 0; j < 15; j++) begin
         @(negedge clk);
         check_val("ign no restart", busy, 0);
         check_val("ign no 2nd done", done, 0);
      end
      check_val("ign product hold", product, 16'h000F);

      // Start held high: one result every 10 cycles
      start = 1'b1; a = 8'd2; b = 8'd3;
      for (int idx = 0; idx < 40; idx++) begin
         @(negedge clk);
         check_val("bk done period", done, ((idx % 10) == 8) && (idx < 30));
         if (done) check_val("bk product", product, 16'h0006);
         if (idx == 29) start = 1'b0;
      end

      // Reset mid-RUN aborts
      start = 1'b1; a = 8'd9; b = 8'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check_val("abort busy before", busy, 1);
      check_val("abort prod before", product, 16'h0006);
      reset_n = 1'b0;
      #1;
      check_val("abort busy", busy, 0);
      check_val("abort done", done, 0);
      check_val("abort product", product, 16'h0000);
      @(negedge clk);
      reset_n = 1'b1;
      for (int j = 0; j < 15; j++) begin
         @(negedge clk);
         check_val("post abort busy", busy, 0);
         check_val("post abort done", done, 0);
         check_val("post abort product", product, 16'h0000);
      end

      // Product hold while idle with toggling operands
      last_prod = 16'h0000;
      run_op("6x7", 8'd6, 8'd7, 16'h002A);
      for (int j = 0; j < 20; j++) begin
         a = 8'(j * 37);
         b = ~a;
         @(negedge clk);
         check_val("hold product", product, 16'h002A);
         check_val("hold done", done, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
